// File: rtl/pov_column_buffer_pkg.sv
// Shared defaults, FSM encoding and the theta-to-column mapping for the POV column buffer.
package pov_column_buffer_pkg;

  localparam int LED_COUNT_DEF  = 52;
  localparam int TEX_WIDTH_DEF  = 256;
  localparam int THETA_BITS_DEF = 6;
  localparam int PX_BITS_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Scale an angle index onto the texture width; defaults reduce to {theta, 2'b00}.
  function automatic logic [7:0] theta_to_col(input logic [31:0] theta,
                                              input int unsigned tex_width,
                                              input int unsigned theta_bits);
    return 8'((theta * tex_width) >> theta_bits);
  endfunction

endpackage

// File: rtl/pov_column_buffer_if.sv
// Bus between the column buffer, the angle generator, the texture ROM and the neopixel driver.
interface pov_column_buffer_if
  import pov_column_buffer_pkg::*;
#(
  parameter int LED_COUNT  = LED_COUNT_DEF,
  parameter int TEX_WIDTH  = TEX_WIDTH_DEF,
  parameter int THETA_BITS = THETA_BITS_DEF,
  parameter int PX_BITS    = PX_BITS_DEF
);
  localparam int ROM_AW = $clog2(TEX_WIDTH * LED_COUNT);

  logic [THETA_BITS-1:0] theta;
  logic [ROM_AW-1:0]     rom_addr;
  logic [23:0]           rom_data;
  logic [PX_BITS-1:0]    next_px_num;
  logic [23:0]           pixel;
  logic [7:0]            col_active;
  logic                  swap_pulse;
  logic                  fill_busy;
  logic [7:0]            coalesced;

  modport master (
    output theta, rom_data, next_px_num,
    input  rom_addr, pixel, col_active, swap_pulse, fill_busy, coalesced
  );

  modport slave (
    input  theta, rom_data, next_px_num,
    output rom_addr, pixel, col_active, swap_pulse, fill_busy, coalesced
  );

endinterface

// File: rtl/pov_column_buffer_bank_ram.sv
// One LED column bank: single write port, single registered read port, no reset on storage.
module pov_bank_ram
  import pov_column_buffer_pkg::*;
#(
  parameter int DEPTH = LED_COUNT_DEF,
  parameter int WIDTH = 24,
  parameter int AW    = PX_BITS_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pov_column_buffer.sv
// Ping-pong LED column buffer: fills the back bank from texture ROM on angle changes and
// swaps it in at the next strip refresh wrap so a frame is never shown half-updated.
module pov_column_buffer
  import pov_column_buffer_pkg::*;
#(
  parameter int LED_COUNT  = LED_COUNT_DEF,
  parameter int TEX_WIDTH  = TEX_WIDTH_DEF,
  parameter int THETA_BITS = THETA_BITS_DEF,
  parameter int PX_BITS    = PX_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pov_column_buffer_if.slave bus
);

  localparam int ROM_AW = $clog2(TEX_WIDTH * LED_COUNT);
  localparam int CNT_W  = $clog2(LED_COUNT + 1);
  localparam logic [PX_BITS-1:0] LAST_PX       = PX_BITS'(LED_COUNT - 1);
  localparam logic [CNT_W-1:0]   CNT_DONE      = CNT_W'(LED_COUNT);
  localparam logic [CNT_W-1:0]   CNT_LAST_ADDR = CNT_W'(LED_COUNT - 1);
  localparam logic [ROM_AW-1:0]  ROW_STRIDE    = ROM_AW'(TEX_WIDTH);

  state_e                state_q;
  logic [THETA_BITS-1:0] theta_q;
  logic [PX_BITS-1:0]    next_px_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ROM_AW-1:0]     rom_addr_q;
  logic [7:0]            fill_col_q;
  logic [7:0]            col_active_q;
  logic [7:0]            coalesced_q;
  logic                  pending_q;
  logic                  active_q;
  logic                  valid_q;
  logic                  swap_q;
  logic                  fill_busy_q;
  logic                  sel_q;
  logic                  in_range_q;

  logic                  theta_chg;
  logic                  wrap;
  logic                  swap_now;
  logic                  px_in_range;
  logic [7:0]            col_now;
  logic                  wr_en;
  logic [PX_BITS-1:0]    wr_addr;
  logic [PX_BITS-1:0]    rd_addr;
  logic [1:0]            bank_we;
  logic [23:0]           rd_data [2];

  assign theta_chg   = (bus.theta != theta_q);
  assign wrap        = (next_px_q == LAST_PX) && (bus.next_px_num == '0);
  assign swap_now    = (state_q == ST_READY) && wrap;
  assign px_in_range = (bus.next_px_num <= LAST_PX);
  assign col_now     = theta_to_col(32'(bus.theta), TEX_WIDTH, THETA_BITS);

  // ROM data lags its address by one cycle, so FILL count c writes row c-1.
  assign wr_en   = !reset && (state_q == ST_FILL) && (cnt_q != '0);
  assign wr_addr = PX_BITS'(cnt_q - CNT_W'(1));
  assign bank_we = wr_en ? (active_q ? 2'b01 : 2'b10) : 2'b00;
  assign rd_addr = px_in_range ? bus.next_px_num : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      pov_bank_ram #(
        .DEPTH (LED_COUNT),
        .WIDTH (24),
        .AW    (PX_BITS)
      ) u_ram (
        .clk   (clk),
        .we    (bank_we[gi]),
        .waddr (wr_addr),
        .wdata (bus.rom_data),
        .raddr (rd_addr),
        .rdata (rd_data[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      theta_q      <= '0;
      next_px_q    <= '0;
      cnt_q        <= '0;
      rom_addr_q   <= '0;
      fill_col_q   <= '0;
      col_active_q <= '0;
      coalesced_q  <= '0;
      pending_q    <= 1'b1;
      active_q     <= 1'b0;
      valid_q      <= 1'b0;
      swap_q       <= 1'b0;
      fill_busy_q  <= 1'b0;
      sel_q        <= 1'b0;
      in_range_q   <= 1'b0;
    end else begin
      theta_q   <= bus.theta;
      next_px_q <= bus.next_px_num;
      swap_q    <= 1'b0;
      // The read issued on the swap edge already targets the newly active bank.
      sel_q      <= active_q ^ swap_now;
      in_range_q <= (valid_q || swap_now) && px_in_range;

      case (state_q)
        ST_IDLE: begin
          if (theta_chg || pending_q) begin
            fill_col_q  <= col_now;
            pending_q   <= 1'b0;
            rom_addr_q  <= ROM_AW'(col_now);
            cnt_q       <= '0;
            fill_busy_q <= 1'b1;
            state_q     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (cnt_q == CNT_DONE) begin
            fill_busy_q <= 1'b0;
            state_q     <= ST_READY;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q < CNT_LAST_ADDR) begin
              rom_addr_q <= rom_addr_q + ROW_STRIDE;
            end
          end
        end
        ST_READY: begin
          if (swap_now) begin
            active_q     <= ~active_q;
            col_active_q <= fill_col_q;
            swap_q       <= 1'b1;
            valid_q      <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Angle changes while busy are deferred into a single follow-up fill.
      if (state_q != ST_IDLE && theta_chg) begin
        if (!pending_q) begin
          pending_q <= 1'b1;
        end else if (coalesced_q != 8'hFF) begin
          coalesced_q <= coalesced_q + 8'd1;
        end
      end
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pixel      = in_range_q ? rd_data[sel_q] : 24'd0;
  assign bus.col_active = col_active_q;
  assign bus.swap_pulse = swap_q;
  assign bus.fill_busy  = fill_busy_q;
  assign bus.coalesced  = coalesced_q;

endmodule

// File: tb/tb_pov_column_buffer.sv
// Directed bench for pov_column_buffer: ROM returns its own address, vectors hand-computed.
module tb_pov_column_buffer;
  import pov_column_buffer_pkg::*;

  localparam int FILL_CYCLES = 53;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   swaps_seen;

  typedef struct {
    logic [5:0]  idx;
    logic [23:0] exp_pixel;
  } vec_t;

  vec_t vecs [12];

  pov_column_buffer_if bus ();

  pov_column_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Texture ROM model: data equals address, one cycle of latency.
  always @(posedge clk) bus.rom_data <= 24'(bus.rom_addr);

  always @(negedge clk) if (bus.swap_pulse === 1'b1) swaps_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else begin
      n_pass++;
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic wait_fill_done(input string name);
    int n = 0;
    while (bus.fill_busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(bus.fill_busy), 32'd0);
  endtask

  task automatic do_wrap(input string name, input logic [7:0] exp_col);
    bus.next_px_num = 6'd51;
    tick();
    bus.next_px_num = 6'd0;
    tick();
    check({name, "_swap_on"}, 32'(bus.swap_pulse), 32'd1);
    check({name, "_col_active"}, 32'(bus.col_active), 32'(exp_col));
    tick();
    check({name, "_swap_off"}, 32'(bus.swap_pulse), 32'd0);
  endtask

  task automatic apply_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.next_px_num = vecs[i].idx;
      tick();
      check($sformatf("vec%0d_px%0d", i, vecs[i].idx), 32'(bus.pixel), 32'(vecs[i].exp_pixel));
    end
  endtask

  initial begin
    int cnt;
    int swaps_before;

    n_pass = 0;
    n_total = 0;
    swaps_seen = 0;

    // Column 0 after the first fill, then column 12 after theta=3.
    vecs[0]  = '{6'd5,  24'd1280};
    vecs[1]  = '{6'd1,  24'd256};
    vecs[2]  = '{6'd51, 24'd13056};
    vecs[3]  = '{6'd52, 24'd0};
    vecs[4]  = '{6'd60, 24'd0};
    vecs[5]  = '{6'd0,  24'd0};
    vecs[6]  = '{6'd1,  24'd268};
    vecs[7]  = '{6'd0,  24'd12};
    vecs[8]  = '{6'd51, 24'd13068};
    vecs[9]  = '{6'd63, 24'd0};
    vecs[10] = '{6'd27, 24'd6924};
    vecs[11] = '{6'd60, 24'd0};

    reset = 1'b1;
    bus.theta = '0;
    bus.next_px_num = '0;
    repeat (3) tick();
    check("rst_pixel", 32'(bus.pixel), 32'd0);
    check("rst_col_active", 32'(bus.col_active), 32'd0);
    check("rst_swap", 32'(bus.swap_pulse), 32'd0);
    check("rst_fill_busy", 32'(bus.fill_busy), 32'd0);
    check("rst_coalesced", 32'(bus.coalesced), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

    // First fill starts on the first edge after release and lasts 53 cycles.
    reset = 1'b0;
    tick();
    check("fill1_start", 32'(bus.fill_busy), 32'd1);
    check("fill1_addr0", 32'(bus.rom_addr), 32'd0);
    cnt = 1;
    while (cnt < 200) begin
      tick();
      if (bus.fill_busy !== 1'b1) break;
      cnt++;
    end
    check("fill1_cycles", 32'(cnt), 32'(FILL_CYCLES));
    check("fill1_addr_hold", 32'(bus.rom_addr), 32'd13056);
    check("pre_swap_pixel", 32'(bus.pixel), 32'd0);
    do_wrap("wrap1", 8'd0);
    apply_vectors(0, 5);

    // Angle change while idle.
    bus.theta = 6'd3;
    tick();
    check("fill2_start", 32'(bus.fill_busy), 32'd1);
    wait_fill_done("fill2_done");
    bus.next_px_num = 6'd5;
    tick();
    check("fill2_old_bank_px5", 32'(bus.pixel), 32'd1280);
    check("fill2_old_col", 32'(bus.col_active), 32'd0);
    do_wrap("wrap2", 8'd12);
    apply_vectors(6, 11);

    // Three angle changes inside one fill collapse into one follow-up fill.
    bus.theta = 6'd5;
    tick();
    check("fill3_start", 32'(bus.fill_busy), 32'd1);
    repeat (3) tick();
    bus.theta = 6'd7;
    repeat (3) tick();
    bus.theta = 6'd9;
    repeat (3) tick();
    bus.theta = 6'd10;
    tick();
    wait_fill_done("fill3_done");
    check("coalesced", 32'(bus.coalesced), 32'd2);
    do_wrap("wrap3", 8'd20);
    check("fill4_pending_start", 32'(bus.fill_busy), 32'd1);
    wait_fill_done("fill4_done");
    do_wrap("wrap4", 8'd40);
    repeat (5) tick();
    check("no_fill5", 32'(bus.fill_busy), 32'd0);
    check("coalesced_hold", 32'(bus.coalesced), 32'd2);
    bus.next_px_num = 6'd2;
    tick();
    check("fill4_px2", 32'(bus.pixel), 32'd552);

    // Completed fill waits indefinitely for a wrap.
    bus.theta = 6'd12;
    tick();
    wait_fill_done("fill6_done");
    bus.next_px_num = 6'd5;
    swaps_before = swaps_seen;
    repeat (500) tick();
    check("no_swap_500", 32'(swaps_seen - swaps_before), 32'd0);
    check("hold_px5", 32'(bus.pixel), 32'd1320);
    check("hold_col", 32'(bus.col_active), 32'd40);
    swaps_before = swaps_seen;
    do_wrap("wrap6", 8'd48);
    check("wrap6_one_pulse", 32'(swaps_seen - swaps_before), 32'd1);
    bus.next_px_num = 6'd5;
    tick();
    check("fill6_px5", 32'(bus.pixel), 32'd1328);

    // Wrap landing on the fill-completion edge must not swap.
    bus.theta = 6'd13;
    bus.next_px_num = 6'd51;
    tick();
    check("fill7_start", 32'(bus.fill_busy), 32'd1);
    repeat (FILL_CYCLES - 1) tick();
    bus.next_px_num = 6'd0;
    tick();
    check("fill7_done_edge", 32'(bus.fill_busy), 32'd0);
    check("fill7_no_swap", 32'(bus.swap_pulse), 32'd0);
    repeat (3) tick();
    check("fill7_col_hold", 32'(bus.col_active), 32'd48);
    do_wrap("wrap7", 8'd52);

    // Reset in the middle of a fill restarts it from row 0.
    bus.theta = 6'd1;
    tick();
    check("fill8_start", 32'(bus.fill_busy), 32'd1);
    repeat (20) tick();
    check("fill8_row20_addr", 32'(bus.rom_addr), 32'd5124);
    reset = 1'b1;
    tick();
    check("mid_rst_fill_busy", 32'(bus.fill_busy), 32'd0);
    check("mid_rst_pixel", 32'(bus.pixel), 32'd0);
    check("mid_rst_col", 32'(bus.col_active), 32'd0);
    check("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    reset = 1'b0;
    tick();
    check("refill_start", 32'(bus.fill_busy), 32'd1);
    check("refill_row0_addr", 32'(bus.rom_addr), 32'd4);
    wait_fill_done("refill_done");
    bus.next_px_num = 6'd3;
    tick();
    check("refill_pre_swap_px", 32'(bus.pixel), 32'd0);
    do_wrap("wrap8", 8'd4);
    bus.next_px_num = 6'd3;
    tick();
    check("refill_px3", 32'(bus.pixel), 32'd772);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pov_column_buffer.md
POV_COLUMN_BUFFER -- requirements
Module: pov_column_buffer

Interface
REQ-001 SHALL have parameter LED_COUNT, default 52, LEDs per strip column.
REQ-002 SHALL have parameter TEX_WIDTH, default 256, texture columns per revolution.
REQ-003 SHALL have parameter THETA_BITS, default 6, angle index width.
REQ-004 SHALL have parameter PX_BITS, default 6, LED index width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port theta  input  THETA_BITS  current angle index from the angle generator.
REQ-008 SHALL have port rom_addr  output  clog2(TEX_WIDTH*LED_COUNT)  texture ROM address, row-major (row*TEX_WIDTH+col).
REQ-009 SHALL have port rom_data  input  24  texture ROM data, valid one cycle after rom_addr.
REQ-010 SHALL have port next_px_num  input  PX_BITS  LED index requested by the neopixel controller.
REQ-011 SHALL have port pixel  output  24  GRB colour for next_px_num.
REQ-012 SHALL have port col_active  output  8  column currently displayed.
REQ-013 SHALL have port swap_pulse  output  1  one-cycle strobe on bank swap.
REQ-014 SHALL have port fill_busy  output  1  high while state is FILL.
REQ-015 SHALL have port coalesced  output  8  saturating count of theta changes merged into a later fill.

Function
REQ-016 SHALL hold two LED_COUNT x 24 banks (ping-pong); one active (read), one back (filled).
REQ-017 SHALL compute column = (theta*TEX_WIDTH) >> THETA_BITS; defaults give {theta,2'b00}.
REQ-018 SHALL register theta each cycle; a change is theta != theta_q.
REQ-019 SHALL implement FSM IDLE, FILL, READY.
REQ-020 IDLE: on theta change or pending flag set, latch column into fill_col, clear pending, go FILL next cycle.
REQ-021 FILL: issue rom_addr for rows 0..LED_COUNT-1 on consecutive cycles; write rom_data into back bank row r one cycle after its address; go READY after final write (LED_COUNT+1 cycles total).
REQ-022 READY: on wrap of next_px_num (previous value LED_COUNT-1, current 0), flip active bank, col_active <= fill_col, assert swap_pulse, go IDLE.
REQ-023 Theta change during FILL or READY SHALL NOT abort; set pending; if pending already set, increment coalesced (saturate at 255).
REQ-024 Wrap in same cycle as FILL completion SHALL NOT swap; swap waits for next wrap.
REQ-025 pixel SHALL be registered read of active bank at next_px_num, latency 1 cycle.
REQ-026 next_px_num >= LED_COUNT SHALL yield pixel 0.
REQ-027 Before first swap after reset, pixel SHALL be 0.
REQ-028 rom_addr SHALL hold its last value outside FILL.

Reset
REQ-029 Reset SHALL set state IDLE, pending=1 (forces immediate fill), active bank 0, pixel 0, col_active 0, swap_pulse 0, fill_busy 0, coalesced 0, valid flag 0, rom_addr 0.
REQ-030 Reset mid-FILL SHALL abandon the fill; bank contents need not clear.

Structure
REQ-031 Shared package SHALL hold LED_COUNT, TEX_WIDTH, THETA_BITS, PX_BITS defaults and FSM state encoding.
REQ-032 One sub-module, pov_bank_ram (1 write, 1 registered read port), SHALL be instantiated twice.

Verification
REQ-033 Reset, theta=0, ROM model data=addr -> fill starts 1 cycle after reset release, 53 cycles FILL, swap at first wrap, pixel for index 5 = 5*256.
REQ-034 theta 0->3 while IDLE after swap -> col_active=12 after next wrap, pixel row 1 = 256+12.
REQ-035 Theta changes 3 times during one FILL -> one extra fill only, coalesced=2, final col_active = last theta*4.
REQ-036 Fill completes; no wrap for 500 cycles -> no swap, pixel unchanged; wrap -> swap_pulse exactly one cycle.
REQ-037 next_px_num=60 -> pixel 0 next cycle.
REQ-038 Assert reset at FILL row 20 -> fill_busy low next cycle, pixel 0, new fill restarts at row 0.
